// File: rtl/dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// rv32i_imm_gen
//   RV32I immediate generator, purely combinational on the instruction word.
//   Ports:
//     inst_i  32-bit instruction word
//     imm_o   32-bit sign-extended immediate (0 for R-type / unknown opcodes)
//
// dispatch_ctrl
//   In-order, single-issue dispatch stage between the fetch queue and the
//   reservation stations. It pops one instruction per cycle, classifies it
//   (INT/MEM/MUL/BR/ILL), stages it with its immediate and a ROB tag, and holds
//   it until the target reservation station accepts it. It also tracks ROB
//   credits so it never allocates more tags than the ROB has entries.
//   Ports:
//     clk, rst                  clock (rising edge), async active-high reset
//     ifq_valid/inst/pc         fetch-queue head
//     ifq_rd_en                 combinational pop strobe for the queue head
//     *_vld / *_rdy             per-station request / accept handshake
//     d_inst/d_pc/d_imm/d_tag   staged payload
//     retire                    ROB freed one entry
//     flush                     drop everything, restore all ROB credits
//     illegal_o                 one-cycle pulse when an unsupported op is dropped
// ---------------------------------------------------------------------------

module rv32i_imm_gen (
  input  logic [31:0] inst_i,
  output logic [31:0] imm_o
);

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  fmt_e fmt;

  always_comb begin
    fmt = FMT_NONE;
    case (inst_i[6:0])
      7'h13, 7'h03, 7'h67: fmt = FMT_I;
      7'h23:               fmt = FMT_S;
      7'h63:               fmt = FMT_B;
      7'h37, 7'h17:        fmt = FMT_U;
      7'h6F:               fmt = FMT_J;
      default:             fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt)
      FMT_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      FMT_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FMT_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                      inst_i[30:25], inst_i[11:8], 1'b0};
      FMT_U: imm_o = {inst_i[31:12], 12'h000};
      FMT_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                      inst_i[20], inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

module dispatch_ctrl #(
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned ROB_DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifq_valid,
  input  logic [31:0]      ifq_inst,
  input  logic [31:0]      ifq_pc,
  output logic             ifq_rd_en,
  output logic             int_vld,
  output logic             mem_vld,
  output logic             mul_vld,
  output logic             br_vld,
  input  logic             int_rdy,
  input  logic             mem_rdy,
  input  logic             mul_rdy,
  input  logic             br_rdy,
  output logic [31:0]      d_inst,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_imm,
  output logic [TAG_W-1:0] d_tag,
  input  logic             retire,
  input  logic             flush,
  output logic             illegal_o
);

  localparam int unsigned FREE_W = $clog2(ROB_DEPTH + 1);
  localparam logic [FREE_W-1:0] FREE_MAX = FREE_W'(ROB_DEPTH);
  localparam logic [TAG_W-1:0]  TAG_LAST = TAG_W'(ROB_DEPTH - 1);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  typedef enum logic [2:0] {
    CLS_INT,
    CLS_MEM,
    CLS_MUL,
    CLS_BR,
    CLS_ILL
  } cls_e;

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d, cls_w;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       imm_w;
  logic [TAG_W-1:0]  tag_cnt_q, tag_cnt_d;
  logic [FREE_W-1:0] free_cnt_q, free_cnt_d;

  logic full;
  logic rob_ok;
  logic req_ok;
  logic sel_rdy;
  logic fire;
  logic ill_drop;
  logic retire_eff;

  rv32i_imm_gen u_imm_gen (
    .inst_i (ifq_inst),
    .imm_o  (imm_w)
  );

  // Classification of the fetch-queue head.
  always_comb begin
    cls_w = CLS_ILL;
    case (ifq_inst[6:0])
      7'h33:               cls_w = (ifq_inst[31:25] == 7'h01) ? CLS_MUL : CLS_INT;
      7'h13, 7'h37, 7'h17: cls_w = CLS_INT;
      7'h03, 7'h23:        cls_w = CLS_MEM;
      7'h63, 7'h6F, 7'h67: cls_w = CLS_BR;
      default:             cls_w = CLS_ILL;
    endcase
  end

  assign full   = (state_q == ST_FULL);
  assign rob_ok = (free_cnt_q != '0);
  // Requests are withheld during a flush so a station never sees vld&rdy
  // for an entry that is being dropped.
  assign req_ok = full & rob_ok & ~flush;

  assign int_vld = req_ok & (cls_q == CLS_INT);
  assign mem_vld = req_ok & (cls_q == CLS_MEM);
  assign mul_vld = req_ok & (cls_q == CLS_MUL);
  assign br_vld  = req_ok & (cls_q == CLS_BR);

  always_comb begin
    sel_rdy = 1'b0;
    case (cls_q)
      CLS_INT: sel_rdy = int_rdy;
      CLS_MEM: sel_rdy = mem_rdy;
      CLS_MUL: sel_rdy = mul_rdy;
      CLS_BR:  sel_rdy = br_rdy;
      default: sel_rdy = 1'b0;
    endcase
  end

  assign fire     = req_ok & sel_rdy;
  assign ill_drop = full & (cls_q == CLS_ILL) & ~flush;
  assign illegal_o = ill_drop;

  // rst term keeps the pop strobe low while the stage is held in reset.
  assign ifq_rd_en = ifq_valid & ~flush & ~rst & (~full | fire | ill_drop);

  assign retire_eff = retire & (free_cnt_q != FREE_MAX);

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    tag_cnt_d  = tag_cnt_q;
    free_cnt_d = free_cnt_q;

    if (flush) begin
      state_d    = ST_EMPTY;
      tag_cnt_d  = '0;
      free_cnt_d = FREE_MAX;
    end else begin
      if (ifq_rd_en) begin
        state_d = ST_FULL;
        cls_d   = cls_w;
        inst_d  = ifq_inst;
        pc_d    = ifq_pc;
        imm_d   = imm_w;
      end else if (fire | ill_drop) begin
        state_d = ST_EMPTY;
      end

      if (fire) begin
        tag_cnt_d = (tag_cnt_q == TAG_LAST) ? '0 : tag_cnt_q + 1'b1;
      end

      case ({fire, retire_eff})
        2'b10:   free_cnt_d = free_cnt_q - 1'b1;
        2'b01:   free_cnt_d = free_cnt_q + 1'b1;
        default: free_cnt_d = free_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      cls_q      <= CLS_ILL;
      inst_q     <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      tag_cnt_q  <= '0;
      free_cnt_q <= FREE_MAX;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      tag_cnt_q  <= tag_cnt_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign d_inst = inst_q;
  assign d_pc   = pc_q;
  assign d_imm  = imm_q;
  assign d_tag  = tag_cnt_q;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// Directed bench for dispatch_ctrl with a 4-entry ROB and 3-bit tags, so the
// tag wraps at ROB_DEPTH-1 rather than at the natural counter overflow.
// ---------------------------------------------------------------------------
module tb_dispatch_ctrl;

  localparam int unsigned TAG_W     = 3;
  localparam int unsigned ROB_DEPTH = 4;

  localparam logic [31:0] ADDI  = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] ADDI2 = 32'h00A0_0113; // addi x2,x0,10
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] MUL   = 32'h0220_8033;
  localparam logic [31:0] BEQ   = 32'hFE00_0EE3;
  localparam logic [31:0] SW    = 32'h0011_2223; // sw x1,4(x2)
  localparam logic [31:0] ILL   = 32'h0000_000B;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifq_valid;
  logic [31:0]      ifq_inst;
  logic [31:0]      ifq_pc;
  logic             ifq_rd_en;
  logic             int_vld, mem_vld, mul_vld, br_vld;
  logic             int_rdy, mem_rdy, mul_rdy, br_rdy;
  logic [31:0]      d_inst, d_pc, d_imm;
  logic [TAG_W-1:0] d_tag;
  logic             retire;
  logic             flush;
  logic             illegal_o;
  logic [3:0]       vlds;

  int tests = 0;
  int fails = 0;

  assign vlds = {int_vld, mem_vld, mul_vld, br_vld};

  dispatch_ctrl #(.TAG_W(TAG_W), .ROB_DEPTH(ROB_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ifq_valid (ifq_valid),
    .ifq_inst  (ifq_inst),
    .ifq_pc    (ifq_pc),
    .ifq_rd_en (ifq_rd_en),
    .int_vld   (int_vld),
    .mem_vld   (mem_vld),
    .mul_vld   (mul_vld),
    .br_vld    (br_vld),
    .int_rdy   (int_rdy),
    .mem_rdy   (mem_rdy),
    .mul_rdy   (mul_rdy),
    .br_rdy    (br_rdy),
    .d_inst    (d_inst),
    .d_pc      (d_pc),
    .d_imm     (d_imm),
    .d_tag     (d_tag),
    .retire    (retire),
    .flush     (flush),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = '0;
    int_rdy = 1'b0; mem_rdy = 1'b0; mul_rdy = 1'b0; br_rdy = 1'b0;
    retire = 1'b0; flush = 1'b0;
    #2;
    chk("rst_rd_en", 32'(ifq_rd_en), 0);
    chk("rst_vld",   32'(vlds), 0);
    chk("rst_ill",   32'(illegal_o), 0);
    chk("rst_tag",   32'(d_tag), 0);
    chk("rst_inst",  d_inst, 0);
    chk("rst_pc",    d_pc, 0);
    chk("rst_imm",   d_imm, 0);
    chk("rst_free",  32'(dut.free_cnt_q), 4);
    cyc(); cyc();
    rst = 1'b0;
    int_rdy = 1'b1; mem_rdy = 1'b1; mul_rdy = 1'b1; br_rdy = 1'b1;

    // Stream int, mem, mul, br back to back.
    ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = 32'h100;
    #1 chk("s1_pop0", 32'(ifq_rd_en), 1);
    cyc();
    ifq_inst = LW; ifq_pc = 32'h104;
    #1 chk("s1_vld_int", 32'(vlds), 4'b1000);
    chk("s1_imm_addi", d_imm, 5);
    chk("s1_tag0", 32'(d_tag), 0);
    chk("s1_pc0", d_pc, 32'h100);
    chk("s1_pop1", 32'(ifq_rd_en), 1);
    cyc();
    ifq_inst = MUL; ifq_pc = 32'h108;
    #1 chk("s1_vld_mem", 32'(vlds), 4'b0100);
    chk("s1_inst_lw", d_inst, LW);
    chk("s1_imm_lw", d_imm, 0);
    chk("s1_tag1", 32'(d_tag), 1);
    cyc();
    ifq_inst = BEQ; ifq_pc = 32'h10C;
    #1 chk("s1_vld_mul", 32'(vlds), 4'b0010);
    chk("s1_inst_mul", d_inst, MUL);
    chk("s1_tag2", 32'(d_tag), 2);
    cyc();
    ifq_valid = 1'b0;
    #1 chk("s1_vld_br", 32'(vlds), 4'b0001);
    chk("s1_imm_beq", d_imm, 32'hFFFF_FFFC);
    chk("s1_tag3", 32'(d_tag), 3);
    chk("s1_nopop", 32'(ifq_rd_en), 0);
    cyc();
    #1 chk("s1_idle_vld", 32'(vlds), 0);
    chk("s1_free0", 32'(dut.free_cnt_q), 0);
    chk("s1_tag_wrap", 32'(d_tag), 0);
    retire = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    #1 chk("ret_refill", 32'(dut.free_cnt_q), 4);
    cyc();
    #1 chk("ret_saturate", 32'(dut.free_cnt_q), 4);
    retire = 1'b0;

    // Staged store held while mem_rdy is low.
    mem_rdy = 1'b0;
    ifq_valid = 1'b1; ifq_inst = SW; ifq_pc = 32'h200;
    #1 chk("s2_pop", 32'(ifq_rd_en), 1);
    cyc();
    ifq_inst = ADDI; ifq_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1 chk("s2_hold_vld", 32'(vlds), 4'b0100);
      chk("s2_hold_inst", d_inst, SW);
      chk("s2_hold_imm", d_imm, 4);
      chk("s2_hold_tag", 32'(d_tag), 0);
      chk("s2_hold_nopop", 32'(ifq_rd_en), 0);
      cyc();
    end
    mem_rdy = 1'b1;
    #1 chk("s2_fire_vld", 32'(vlds), 4'b0100);
    chk("s2_fire_pop", 32'(ifq_rd_en), 1);
    cyc();
    ifq_valid = 1'b0;
    #1 chk("s2_next_vld", 32'(vlds), 4'b1000);
    chk("s2_next_inst", d_inst, ADDI);
    chk("s2_next_tag", 32'(d_tag), 1);
    cyc();
    #1 chk("s2_free", 32'(dut.free_cnt_q), 2);
    chk("s2_empty", 32'(vlds), 0);

    // ROB credit exhaustion and tag wrap.
    ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = 32'h300;
    #1 chk("s3_pop", 32'(ifq_rd_en), 1);
    cyc();
    #1 chk("s3_vld_a", 32'(vlds), 4'b1000);
    chk("s3_tag_a", 32'(d_tag), 2);
    cyc();
    #1 chk("s3_vld_b", 32'(vlds), 4'b1000);
    chk("s3_tag_b", 32'(d_tag), 3);
    cyc();
    #1 chk("s3_full_vld", 32'(vlds), 0);
    chk("s3_full_nopop", 32'(ifq_rd_en), 0);
    chk("s3_full_tag", 32'(d_tag), 0);
    chk("s3_full_free", 32'(dut.free_cnt_q), 0);
    cyc();
    #1 chk("s3_full_hold", 32'(vlds), 0);
    retire = 1'b1;
    cyc();
    retire = 1'b0;
    #1 chk("s3_wrap_vld", 32'(vlds), 4'b1000);
    chk("s3_wrap_tag", 32'(d_tag), 0);
    chk("s3_wrap_free", 32'(dut.free_cnt_q), 1);
    chk("s3_wrap_pop", 32'(ifq_rd_en), 1);
    cyc();
    #1 chk("s3_full2_vld", 32'(vlds), 0);
    chk("s3_full2_tag", 32'(d_tag), 1);
    retire = 1'b1;
    cyc();
    ifq_valid = 1'b0;
    #1 chk("s3_fr_vld", 32'(vlds), 4'b1000);
    chk("s3_fr_free_pre", 32'(dut.free_cnt_q), 1);
    cyc();
    retire = 1'b0;
    #1 chk("s3_fr_free", 32'(dut.free_cnt_q), 1);
    chk("s3_fr_tag", 32'(d_tag), 2);
    chk("s3_fr_empty", 32'(vlds), 0);
    retire = 1'b1;
    cyc(); cyc(); cyc();
    retire = 1'b0;
    #1 chk("s3_refill", 32'(dut.free_cnt_q), 4);

    // Illegal opcode between two addi.
    ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = 32'h400;
    #1;
    cyc();
    ifq_inst = ILL; ifq_pc = 32'h404;
    #1 chk("s4_vld_a", 32'(vlds), 4'b1000);
    chk("s4_tag_a", 32'(d_tag), 2);
    chk("s4_noill_a", 32'(illegal_o), 0);
    cyc();
    ifq_inst = ADDI2; ifq_pc = 32'h408;
    #1 chk("s4_ill_vld", 32'(vlds), 0);
    chk("s4_ill_pulse", 32'(illegal_o), 1);
    chk("s4_ill_tag", 32'(d_tag), 3);
    chk("s4_ill_pop", 32'(ifq_rd_en), 1);
    cyc();
    ifq_valid = 1'b0;
    #1 chk("s4_ill_gone", 32'(illegal_o), 0);
    chk("s4_vld_b", 32'(vlds), 4'b1000);
    chk("s4_tag_b", 32'(d_tag), 3);
    chk("s4_imm_b", d_imm, 10);
    chk("s4_pc_b", d_pc, 32'h408);
    cyc();
    #1 chk("s4_free", 32'(dut.free_cnt_q), 2);
    chk("s4_tag_end", 32'(d_tag), 0);

    // Flush with a staged int, rdy high and a coincident retire.
    ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = 32'h500;
    #1;
    cyc();
    #1 chk("s5_vld_a", 32'(vlds), 4'b1000);
    chk("s5_tag_a", 32'(d_tag), 0);
    cyc();
    flush = 1'b1; retire = 1'b1;
    #1 chk("s5_fl_nopop", 32'(ifq_rd_en), 0);
    chk("s5_fl_noill", 32'(illegal_o), 0);
    chk("s5_fl_tag_pre", 32'(d_tag), 1);
    cyc();
    flush = 1'b0; retire = 1'b0; ifq_valid = 1'b0;
    #1 chk("s5_vld", 32'(vlds), 0);
    chk("s5_tag", 32'(d_tag), 0);
    chk("s5_free", 32'(dut.free_cnt_q), 4);
    cyc();

    // Asynchronous reset with a mul staged.
    mul_rdy = 1'b0;
    ifq_valid = 1'b1; ifq_inst = ADDI; ifq_pc = 32'h600;
    #1;
    cyc();
    ifq_inst = MUL; ifq_pc = 32'h604;
    #1 chk("s6_vld_a", 32'(vlds), 4'b1000);
    cyc();
    #1 chk("s6_mul_vld", 32'(vlds), 4'b0010);
    chk("s6_mul_tag", 32'(d_tag), 1);
    #1 rst = 1'b1;
    #1 chk("s6_rst_vld", 32'(vlds), 0);
    chk("s6_rst_tag", 32'(d_tag), 0);
    chk("s6_rst_inst", d_inst, 0);
    chk("s6_rst_free", 32'(dut.free_cnt_q), 4);
    chk("s6_rst_nopop", 32'(ifq_rd_en), 0);
    #1 rst = 1'b0;
    mul_rdy = 1'b1;
    ifq_inst = ADDI; ifq_pc = 32'h700;
    cyc();
    ifq_valid = 1'b0;
    #1 chk("s6_post_vld", 32'(vlds), 4'b1000);
    chk("s6_post_tag", 32'(d_tag), 0);
    chk("s6_post_pc", d_pc, 32'h700);
    cyc();
    #1 chk("s6_post_free", 32'(dut.free_cnt_q), 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
